// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction-fetch and load/store ports.
// Grants alternate I/D under contention; each access runs exactly MEM_LATENCY cycles.
module unified_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIAcc, StDAcc} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              last;
  logic              take_i, take_d, go_idle;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    take_i  = 1'b0;
    take_d  = 1'b0;
    go_idle = 1'b0;

    // The port acked at this edge is masked, so the other port wins if it is waiting.
    unique case (state_q)
      StIdle: begin
        if (d_req)      take_d = 1'b1;
        else if (i_req) take_i = 1'b1;
      end
      StDAcc: begin
        if (!last)      cnt_d = cnt_q - CntW'(1);
        else if (i_req) take_i = 1'b1;
        else            go_idle = 1'b1;
      end
      StIAcc: begin
        if (!last)      cnt_d = cnt_q - CntW'(1);
        else if (d_req) take_d = 1'b1;
        else            go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (take_d) begin
      state_d = StDAcc;
      cnt_d   = CntLoad;
      addr_d  = d_addr;
      wr_d    = d_wr;
      wdata_d = d_wr ? d_wdata : '0;
    end else if (take_i) begin
      state_d = StIAcc;
      cnt_d   = CntLoad;
      addr_d  = i_addr;
      wr_d    = 1'b0;
      wdata_d = '0;
    end else if (go_idle) begin
      state_d = StIdle;
      cnt_d   = '0;
      addr_d  = '0;
      wr_d    = 1'b0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Latched registers are cleared on return to idle, so they drive the memory directly.
  assign mem_en    = (state_q != StIdle);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);

  assign i_ack   = (state_q == StIAcc) && last;
  assign d_ack   = (state_q == StDAcc) && last;
  assign i_rdata = i_ack ? mem_rdata : '0;
  assign d_rdata = (d_ack && !wr_q) ? mem_rdata : '0;
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a MEM_LATENCY=4 instance with a small memory model
// and a MEM_LATENCY=1 instance with a synthetic address-derived read path.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Latency-4 instance
  logic        i_req = 0, d_req = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_ack, i_stall, d_ack, d_stall, mem_en, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] model [256];

  unified_mem_arbiter #(.MEM_LATENCY(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = model[mem_addr[7:0]];
  always @(posedge clk) if (mem_en && mem_wr) model[mem_addr[7:0]] <= mem_wdata;

  // Latency-1 instance
  logic        s_i_req = 0, s_d_req = 0, s_d_wr = 0;
  logic [15:0] s_i_addr = 0, s_d_addr = 0, s_d_wdata = 0;
  logic        s_i_ack, s_i_stall, s_d_ack, s_d_stall, s_mem_en, s_mem_wr, s_busy;
  logic [15:0] s_i_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;

  unified_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(16), .DATA_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(s_i_req), .i_addr(s_i_addr), .i_ack(s_i_ack), .i_rdata(s_i_rdata),
    .i_stall(s_i_stall),
    .d_req(s_d_req), .d_wr(s_d_wr), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
    .d_ack(s_d_ack), .d_rdata(s_d_rdata), .d_stall(s_d_stall),
    .mem_en(s_mem_en), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .busy(s_busy)
  );

  assign s_mem_rdata = s_mem_addr + 16'h1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Request must already be driven; walks the four access cycles checking every output.
  task automatic run_access(input string tag, input bit is_d, input logic [15:0] a,
                            input logic [15:0] rd, input bit wr, input logic [15:0] wd,
                            input bit drop);
    bit last;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      last = (k == 3);
      check({tag, "_en"}, 32'(mem_en), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(a));
      check({tag, "_wr"}, 32'(mem_wr), 32'(wr));
      check({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
      check({tag, "_iack"}, 32'(i_ack), 32'(!is_d && last));
      check({tag, "_dack"}, 32'(d_ack), 32'(is_d && last));
      check({tag, "_irdata"}, 32'(i_rdata), (!is_d && last) ? 32'(rd) : 32'd0);
      check({tag, "_drdata"}, 32'(d_rdata), (is_d && last && !wr) ? 32'(rd) : 32'd0);
      check({tag, "_istall"}, 32'(i_stall), 32'(i_req && !(!is_d && last)));
      check({tag, "_dstall"}, 32'(d_stall), 32'(d_req && !(is_d && last)));
      if (last && drop) begin
        if (is_d) d_req = 0;
        else      i_req = 0;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"}, 32'(mem_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wr"}, 32'(mem_wr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_acks"}, 32'({i_ack, d_ack}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    model[8'h10] = 16'hB123;
    model[8'h00] = 16'h1111;
    model[8'h02] = 16'h2222;

    // Reset: outputs quiet, stalls follow requests
    @(negedge clk);
    @(negedge clk);
    check_idle("rst");
    check("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    i_req = 1;
    d_req = 1;
    @(negedge clk);
    check("rst_istall", 32'(i_stall), 32'd1);
    check("rst_dstall", 32'(d_stall), 32'd1);
    check("rst_busy_req", 32'(busy), 32'd0);
    i_req = 0;
    d_req = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_idle("idle");

    // Single fetch
    i_req = 1;
    i_addr = 16'h0010;
    #1 check("fetch_stall0", 32'(i_stall), 32'd1);
    run_access("fetch", 0, 16'h0010, 16'hB123, 0, 16'h0, 1);
    @(negedge clk);
    check_idle("fetch_after");

    // Store then load back
    d_req = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'h5A5A;
    run_access("store", 1, 16'h0040, 16'h0, 1, 16'h5A5A, 1);
    @(negedge clk);
    check_idle("store_after");
    d_req = 1; d_wr = 0;
    run_access("load", 1, 16'h0040, 16'h5A5A, 0, 16'h0, 1);
    @(negedge clk);
    check_idle("load_after");

    // Continuous contention: D first, then strict alternation with no gap
    d_req = 1; d_wr = 0; d_addr = 16'h0040;
    i_req = 1; i_addr = 16'h0010;
    for (int c = 0; c < 24; c++) begin
      bit dphase, lst;
      @(negedge clk);
      dphase = ((c / 4) % 2) == 0;
      lst = (c % 4) == 3;
      check("cont_en", 32'(mem_en), 32'd1);
      check("cont_addr", 32'(mem_addr), dphase ? 32'h40 : 32'h10);
      check("cont_dack", 32'(d_ack), 32'(dphase && lst));
      check("cont_iack", 32'(i_ack), 32'(!dphase && lst));
      check("cont_rdata", 32'(dphase ? d_rdata : i_rdata), lst ? (dphase ? 32'h5A5A : 32'hB123)
                                                                : 32'd0);
      if (c == 23) begin
        d_req = 0;
        i_req = 0;
      end
    end
    @(negedge clk);
    check_idle("cont_after");

    // Back-to-back fetches: one idle cycle, mid-access address change ignored
    i_req = 1; i_addr = 16'h0000;
    run_access("b2b0", 0, 16'h0000, 16'h1111, 0, 16'h0, 0);
    i_addr = 16'h0002;
    @(negedge clk);
    check_idle("b2b_gap");
    check("b2b_gap_stall", 32'(i_stall), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b1_addr", 32'(mem_addr), 32'h2);
      check("b2b1_ack", 32'(i_ack), 32'(k == 3));
      if (k == 1) i_addr = 16'h0099;
      if (k == 3) begin
        check("b2b1_rdata", 32'(i_rdata), 32'h2222);
        i_req = 0;
      end
    end
    @(negedge clk);
    check_idle("b2b_after");

    // Reset mid-access: abandoned at once, no ack afterwards
    i_req = 1; i_addr = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1;
    #1 check_idle("mid_rst");
    i_req = 0;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle("mid_post");
    end

    // Latency-1 instance: single-cycle fetch, then per-cycle alternation
    s_i_req = 1; s_i_addr = 16'h0020;
    @(negedge clk);
    check("l1_iack", 32'(s_i_ack), 32'd1);
    check("l1_irdata", 32'(s_i_rdata), 32'h1020);
    check("l1_istall", 32'(s_i_stall), 32'd0);
    s_i_req = 0;
    @(negedge clk);
    check("l1_idle", 32'({s_busy, s_mem_en, s_i_ack}), 32'd0);
    s_i_req = 1; s_d_req = 1; s_d_wr = 0; s_d_addr = 16'h0030;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("l1_dack", 32'(s_d_ack), 32'(c % 2 == 0));
      check("l1_iack_alt", 32'(s_i_ack), 32'(c % 2 == 1));
      check("l1_addr", 32'(s_mem_addr), (c % 2 == 0) ? 32'h30 : 32'h20);
      check("l1_rdata", 32'(s_d_rdata | s_i_rdata), (c % 2 == 0) ? 32'h1030 : 32'h1020);
      if (c == 5) begin
        s_i_req = 0;
        s_d_req = 0;
      end
    end
    @(negedge clk);
    check("l1_after", 32'({s_busy, s_mem_en}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
